// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | pipeline_hazard_ctrl                                                    |
// | Stall/flush sequencer for the 5-stage RV32I pipeline: load-use bubbles, |
// | branch redirect flushes, memory-wait freeze, timeout trap, perf counts. |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module pipeline_hazard_ctrl #(
  parameter int CNT_W        = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int WAIT_W       = 8,
  parameter int MEM_TIMEOUT  = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic             ex_write_reg,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             bubble_ex,
  output logic             flush_id,
  output logic             pc_redirect,
  output logic             mem_timeout,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_MEMWAIT  = 2'd2,
    ST_UNUSED   = 2'd3
  } state_t;

  localparam logic [3:0]        c_REMAIN_INIT = 4'(FLUSH_CYCLES - 1);
  localparam logic [WAIT_W-1:0] c_TIMEOUT     = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] c_WAIT_ONE    = WAIT_W'(1);

  state_t            r_state, w_state_nxt;
  logic              r_ret_redirect, w_ret_nxt;
  logic [3:0]        r_remain, w_remain_nxt;
  logic [WAIT_W-1:0] r_wait, w_wait_nxt;
  logic [CNT_W-1:0]  r_stall_count, r_flush_count;

  logic w_memstall, w_loaduse;
  logic w_stall_if, w_stall_id, w_stall_ex, w_bubble_ex;
  logic w_flush_id, w_pc_redirect, w_mem_timeout;

  assign w_memstall = mem_req & ~mem_ready;
  assign w_loaduse  = id_valid & ex_valid & ex_is_load & ex_write_reg & (ex_rd != 5'd0) &
                      ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));

  always_comb begin
    w_state_nxt   = r_state;
    w_ret_nxt     = r_ret_redirect;
    w_remain_nxt  = r_remain;
    w_wait_nxt    = r_wait;
    w_stall_if    = 1'b0;
    w_stall_id    = 1'b0;
    w_stall_ex    = 1'b0;
    w_bubble_ex   = 1'b0;
    w_flush_id    = 1'b0;
    w_pc_redirect = 1'b0;
    w_mem_timeout = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_memstall) begin
          // Freeze beats a branch: EX is held, so the branch is seen again on return.
          w_stall_if  = 1'b1;
          w_stall_id  = 1'b1;
          w_stall_ex  = 1'b1;
          w_state_nxt = ST_MEMWAIT;
          w_ret_nxt   = 1'b0;
          w_wait_nxt  = c_WAIT_ONE;
        end else if (ex_branch_taken) begin
          w_pc_redirect = 1'b1;
          w_flush_id    = 1'b1;
          w_bubble_ex   = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            w_state_nxt  = ST_REDIRECT;
            w_remain_nxt = c_REMAIN_INIT;
          end
        end else if (w_loaduse) begin
          w_stall_if  = 1'b1;
          w_stall_id  = 1'b1;
          w_bubble_ex = 1'b1;
        end
      end
      ST_REDIRECT: begin
        w_flush_id = 1'b1;
        if (w_memstall) begin
          w_stall_if  = 1'b1;
          w_stall_id  = 1'b1;
          w_stall_ex  = 1'b1;
          w_state_nxt = ST_MEMWAIT;
          w_ret_nxt   = 1'b1;
          w_wait_nxt  = c_WAIT_ONE;
        end else begin
          w_remain_nxt = r_remain - 4'd1;
          if (r_remain <= 4'd1) begin
            w_state_nxt = ST_RUN;
          end
        end
      end
      ST_MEMWAIT: begin
        w_flush_id = r_ret_redirect;
        if (r_wait != '1) begin
          w_wait_nxt = r_wait + c_WAIT_ONE;
        end
        if (mem_ready) begin
          w_state_nxt = r_ret_redirect ? ST_REDIRECT : ST_RUN;
        end else if (r_wait == c_TIMEOUT) begin
          w_mem_timeout = 1'b1;
          w_state_nxt   = r_ret_redirect ? ST_REDIRECT : ST_RUN;
        end else begin
          w_stall_if = 1'b1;
          w_stall_id = 1'b1;
          w_stall_ex = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_RUN;
      r_ret_redirect <= 1'b0;
      r_remain       <= 4'd0;
      r_wait         <= '0;
      r_stall_count  <= '0;
      r_flush_count  <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_ret_redirect <= w_ret_nxt;
      r_remain       <= w_remain_nxt;
      r_wait         <= w_wait_nxt;
      if (w_stall_if && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
      if (w_pc_redirect && (r_flush_count != '1)) begin
        r_flush_count <= r_flush_count + CNT_W'(1);
      end
    end
  end

  // Mealy outputs follow inputs combinationally, so gate them to stay quiet in reset.
  assign stall_if    = w_stall_if    & rst_n;
  assign stall_id    = w_stall_id    & rst_n;
  assign stall_ex    = w_stall_ex    & rst_n;
  assign bubble_ex   = w_bubble_ex   & rst_n;
  assign flush_id    = w_flush_id    & rst_n;
  assign pc_redirect = w_pc_redirect & rst_n;
  assign mem_timeout = w_mem_timeout & rst_n;
  assign state       = r_state;
  assign stall_count = r_stall_count;
  assign flush_count = r_flush_count;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_pipeline_hazard_ctrl                                                 |
// | Directed vectors with hand-computed expectations for the hazard control.|
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_uses_rs1, id_uses_rs2;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       ex_valid, ex_is_load, ex_write_reg, ex_branch_taken;
  logic       mem_req, mem_ready;

  logic        stall_if, stall_id, stall_ex, bubble_ex, flush_id, pc_redirect, mem_timeout;
  logic [1:0]  state;
  logic [31:0] stall_count, flush_count;

  logic        s_stall_if, s_stall_id, s_stall_ex, s_bubble_ex, s_flush_id, s_pc_redirect, s_mem_timeout;
  logic [1:0]  s_state;
  logic [1:0]  s_stall_count, s_flush_count;

  logic [6:0] ctl, s_ctl;
  assign ctl   = {stall_if, stall_id, stall_ex, bubble_ex, flush_id, pc_redirect, mem_timeout};
  assign s_ctl = {s_stall_if, s_stall_id, s_stall_ex, s_bubble_ex, s_flush_id, s_pc_redirect, s_mem_timeout};

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(32), .FLUSH_CYCLES(2), .WAIT_W(8), .MEM_TIMEOUT(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_write_reg(ex_write_reg), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .bubble_ex(bubble_ex),
    .flush_id(flush_id), .pc_redirect(pc_redirect), .mem_timeout(mem_timeout),
    .state(state), .stall_count(stall_count), .flush_count(flush_count)
  );

  // Narrow-counter, single-flush-cycle variant driven by the same stimulus.
  pipeline_hazard_ctrl #(.CNT_W(2), .FLUSH_CYCLES(1), .WAIT_W(8), .MEM_TIMEOUT(4)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_write_reg(ex_write_reg), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .stall_if(s_stall_if), .stall_id(s_stall_id), .stall_ex(s_stall_ex), .bubble_ex(s_bubble_ex),
    .flush_id(s_flush_id), .pc_redirect(s_pc_redirect), .mem_timeout(s_mem_timeout),
    .state(s_state), .stall_count(s_stall_count), .flush_count(s_flush_count)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Inputs are applied at posedge+1; outputs are sampled at the following negedge.
  task automatic cyc(input string tag, input logic [6:0] exp_ctl, input logic [1:0] exp_st);
    #4;
    chk({tag, ".ctl"}, 32'(ctl), 32'(exp_ctl));
    chk({tag, ".state"}, 32'(state), 32'(exp_st));
    tick();
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_valid = 0; ex_is_load = 0; ex_write_reg = 0; ex_rd = 0;
    ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  // ctl bit order: stall_if stall_id stall_ex bubble_ex flush_id pc_redirect mem_timeout
  localparam logic [6:0] C_NONE   = 7'b0000000;
  localparam logic [6:0] C_LDUSE  = 7'b1101000;
  localparam logic [6:0] C_BRANCH = 7'b0001110;
  localparam logic [6:0] C_FLUSH  = 7'b0000100;
  localparam logic [6:0] C_FREEZE = 7'b1110000;
  localparam logic [6:0] C_FRZFL  = 7'b1110100;
  localparam logic [6:0] C_TMO    = 7'b0000001;

  initial begin
    clear_inputs();
    rst_n = 0;
    mem_req = 1; ex_branch_taken = 1;
    #3;
    chk("rst.ctl", 32'(ctl), 32'(C_NONE));
    chk("rst.state", 32'(state), 0);
    chk("rst.stall_count", stall_count, 0);
    chk("rst.flush_count", flush_count, 0);
    tick();
    clear_inputs();
    tick();
    rst_n = 1;

    // Load-use: lw x5 in EX, add reading x5 in ID
    id_valid = 1; id_rs1 = 5; id_uses_rs1 = 1;
    ex_valid = 1; ex_is_load = 1; ex_write_reg = 1; ex_rd = 5;
    cyc("lu.hit", C_LDUSE, 0);
    ex_valid = 0;
    cyc("lu.after", C_NONE, 0);
    chk("lu.stall_count", stall_count, 1);
    ex_valid = 1; ex_rd = 0; id_rs1 = 0;
    cyc("lu.x0", C_NONE, 0);
    ex_rd = 5; id_rs1 = 5; id_uses_rs1 = 0;
    cyc("lu.nouse", C_NONE, 0);
    id_uses_rs2 = 1; id_rs2 = 5;
    cyc("lu.rs2", C_LDUSE, 0);
    clear_inputs();
    chk("lu.stall_count2", stall_count, 2);

    // Taken branch, two flush cycles
    ex_branch_taken = 1;
    #4;
    chk("br.sat_ctl", 32'(s_ctl), 32'(C_BRANCH));
    #0 cyc("br.c0", C_BRANCH, 0);
    ex_branch_taken = 0;
    #4;
    chk("br.sat_c1", 32'(s_ctl), 32'(C_NONE));
    #0 cyc("br.c1", C_FLUSH, 1);
    cyc("br.c2", C_NONE, 0);
    chk("br.flush_count", flush_count, 1);

    // Memory stall, ready low for 3 cycles
    mem_req = 1; mem_ready = 0;
    cyc("ms.c0", C_FREEZE, 0);
    cyc("ms.c1", C_FREEZE, 2);
    cyc("ms.c2", C_FREEZE, 2);
    mem_ready = 1;
    cyc("ms.rdy", C_NONE, 2);
    mem_req = 0; mem_ready = 0;
    cyc("ms.back", C_NONE, 0);
    chk("ms.stall_count", stall_count, 5);

    // Branch coincident with memstall: freeze first, redirect afterwards
    ex_branch_taken = 1; mem_req = 1;
    cyc("bm.c0", C_FREEZE, 0);
    cyc("bm.c1", C_FREEZE, 2);
    mem_ready = 1;
    cyc("bm.rdy", C_NONE, 2);
    mem_req = 0; mem_ready = 0;
    cyc("bm.redir", C_BRANCH, 0);
    ex_branch_taken = 0;
    cyc("bm.flush", C_FLUSH, 1);
    cyc("bm.run", C_NONE, 0);
    chk("bm.flush_count", flush_count, 2);
    chk("bm.stall_count", stall_count, 7);

    // REDIRECT interrupted by memstall: flush_id held across the wait
    ex_branch_taken = 1;
    cyc("rm.c0", C_BRANCH, 0);
    ex_branch_taken = 0; mem_req = 1;
    cyc("rm.c1", C_FRZFL, 1);
    mem_ready = 1;
    cyc("rm.rdy", C_FLUSH, 2);
    mem_req = 0; mem_ready = 0;
    cyc("rm.c3", C_FLUSH, 1);
    cyc("rm.run", C_NONE, 0);
    chk("rm.flush_count", flush_count, 3);
    chk("rm.stall_count", stall_count, 8);

    // Timeout with MEM_TIMEOUT = 4
    mem_req = 1;
    cyc("to.c0", C_FREEZE, 0);
    cyc("to.w1", C_FREEZE, 2);
    cyc("to.w2", C_FREEZE, 2);
    cyc("to.w3", C_FREEZE, 2);
    #4;
    chk("to.w4.ctl", 32'(ctl), 32'(C_TMO));
    chk("to.w4.state", 32'(state), 2);
    mem_req = 0;
    tick();
    cyc("to.back", C_NONE, 0);
    chk("to.stall_count", stall_count, 12);
    chk("sat.stall_count", 32'(s_stall_count), 3);
    chk("sat.flush_count", 32'(s_flush_count), 3);

    // Asynchronous reset mid-wait
    mem_req = 1;
    cyc("ar.c0", C_FREEZE, 0);
    #4;
    chk("ar.wait.ctl", 32'(ctl), 32'(C_FREEZE));
    rst_n = 0;
    #1;
    chk("ar.ctl", 32'(ctl), 32'(C_NONE));
    chk("ar.state", 32'(state), 0);
    chk("ar.stall_count", stall_count, 0);
    chk("ar.flush_count", flush_count, 0);
    mem_req = 0;
    tick();
    rst_n = 1;
    cyc("ar.post", C_NONE, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32I pipeline (IF → ID/decoder → EX → MEM → WB).
- Watches the decoded operand registers in ID, the load/writeback info in EX, branch/jump resolution in EX, and the data-memory handshake in MEM.
- Drives per-stage stall, flush and bubble controls plus the PC-redirect select.
- Keeps saturating performance counters and raises a memory-timeout trap.

Parameters:
- CNT_W, 32, width of the stall/flush performance counters.
- FLUSH_CYCLES, 2, number of consecutive cycles flush_id is asserted after a taken branch/jump (1..15).
- WAIT_W, 8, width of the memory-wait counter.
- MEM_TIMEOUT, 255, wait cycles after which a memory access is abandoned (< 2^WAIT_W).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- id_valid  in  1  ID holds a valid instruction.
- id_rs1  in  5  ID source register 1 number.
- id_rs2  in  5  ID source register 2 number.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_valid  in  1  EX holds a valid instruction.
- ex_is_load  in  1  EX instruction is a load (info_load != NOTLOAD).
- ex_write_reg  in  1  EX instruction writes rd.
- ex_rd  in  5  EX destination register number.
- ex_branch_taken  in  1  EX resolved a taken branch, JAL or JALR.
- mem_req  in  1  MEM stage has a load/store outstanding this cycle.
- mem_ready  in  1  data memory completes the access this cycle.
- stall_if  out  1  hold PC and IF/ID register.
- stall_id  out  1  hold ID/EX register.
- stall_ex  out  1  hold EX/MEM register.
- bubble_ex  out  1  load a NOP into ID/EX.
- flush_id  out  1  invalidate IF/ID register. Overrides stall_id.
- pc_redirect  out  1  select the EX branch target as next PC.
- mem_timeout  out  1  one-cycle trap pulse.
- state  out  2  FSM state, for debug.
- stall_count  out  CNT_W  cycles with stall_if = 1.
- flush_count  out  CNT_W  number of redirects taken.

Behaviour:
- States: RUN = 0, REDIRECT = 1, MEMWAIT = 2. Encoding 3 is unreachable and recovers to RUN.
- Control outputs are Mealy: combinational from state and inputs, same cycle.
- Reset:
  - While rst_n = 0, every output is 0.
  - state = RUN; flush counter, wait counter, return flag, stall_count and flush_count = 0.
  - Reset mid-operation discards any pending redirect or wait.
- memstall = mem_req & !mem_ready.
- loaduse = id_valid & ex_valid & ex_is_load & ex_write_reg & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
- RUN, priority order:
  1. memstall: stall_if = stall_id = stall_ex = 1. Next state MEMWAIT, ret = RUN, wait counter = 1.
  2. Else ex_branch_taken: pc_redirect = 1, flush_id = 1, bubble_ex = 1, flush_count++.
     - FLUSH_CYCLES = 1: stay in RUN.
     - Otherwise: next state REDIRECT, remaining = FLUSH_CYCLES - 1.
  3. Else loaduse: stall_if = stall_id = 1, bubble_ex = 1. Stay in RUN. The bubble removes the hazard next cycle, so the penalty is exactly 1 cycle.
- REDIRECT:
  - flush_id = 1. ex_branch_taken and loaduse are ignored, because EX holds a bubble.
  - memstall: additionally stall_if = stall_id = stall_ex = 1. Next state MEMWAIT, ret = REDIRECT; remaining is not decremented.
  - Otherwise remaining--. When remaining reaches 0, next state RUN.
- MEMWAIT:
  - stall_if = stall_id = stall_ex = 1 while mem_ready = 0; the wait counter increments each cycle.
  - REDIRECT-return flush: if ret = REDIRECT, flush_id = 1 throughout.
  - mem_ready = 1: freeze outputs deassert in that same cycle; next state = ret.
  - Timeout: wait counter == MEM_TIMEOUT with mem_ready = 0 → mem_timeout = 1 for one cycle, freeze released, next state = ret.
- Simultaneous events:
  - memstall with branch in RUN: freeze wins. EX is held, so ex_branch_taken is re-evaluated on return to RUN.
  - Branch with loaduse: the branch wins and the ID instruction is flushed.
- Counters saturate at all-ones and never wrap.
- stall_if, stall_id and stall_ex are never asserted without stall_if; flush_id is never asserted with pc_redirect outside RUN.

Test Plan:
- Load-use: EX lw x5 (ex_is_load = 1, ex_rd = 5), ID add rs1 = 5 → 1 cycle with stall_if = stall_id = bubble_ex = 1, then all 0. stall_count = 1. With ex_rd = 0, or id_uses_rs1 = 0, no stall.
- Taken branch, FLUSH_CYCLES = 2 → cycle 0: pc_redirect = flush_id = bubble_ex = 1. Cycle 1: flush_id only, state = 1. Cycle 2: state = 0. flush_count = 1.
- mem_req = 1 with mem_ready low for 3 cycles → stall_if/id/ex high for exactly 3 cycles, released in the mem_ready cycle; stall_count = 3.
- Branch + memstall in the same cycle → 2 frozen cycles, no pc_redirect, then pc_redirect = 1 in the first RUN cycle.
- REDIRECT interrupted by a 2-cycle memstall → flush_id high across the whole wait; total flush_id cycles = 1 + 2 + 1. Returns to RUN.
- MEM_TIMEOUT = 4, mem_ready held 0 → mem_timeout pulses on the 4th wait cycle, state = 0 next. Asserting rst_n = 0 mid-wait zeroes all outputs and counters immediately.
